gate_vector_sequencer: RTL

Self-checking stimulus stage for the basic Boolean gate set (AND, OR, NOR, NAND, XOR, XNOR, INVERTER). It sits directly upstream of the gates: it drives the shared `a`/`b` inputs through the full 2-input truth table, holds each vector for a programmable number of cycles, and samples the seven gate outputs. It compares each sample against a built-in reference model and reports a per-gate error mask, an error count, and pass/fail, replacing hand-timed stimulus with a clocked, repeatable sweep.

---
 rtl/boolean_pkg.sv | 29 ++
 rtl/gate_expected.sv | 20 ++
 rtl/gate_vector_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/boolean_pkg.sv
// Shared definitions for the Boolean gate checker: gate bit positions, sequencer states, sizes.
// Pure declarations and a popcount helper; no latency, no flow control.
package boolean_pkg;
  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;
  localparam int GATE_INV  = 6;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [ERR_W-1:0] popcount7(input logic [6:0] v);
    logic [ERR_W-1:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) begin
      n = n + ERR_W'(v[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/gate_expected.sv
// Combinational reference outputs of the 7-gate set for inputs (a, b).
// Zero latency; no flow control.
module gate_expected
  import boolean_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] y_exp
);
  always_comb begin
    y_exp            = '0;
    y_exp[GATE_AND]  = a & b;
    y_exp[GATE_OR]   = a | b;
    y_exp[GATE_NOR]  = ~(a | b);
    y_exp[GATE_NAND] = ~(a & b);
    y_exp[GATE_XOR]  = a ^ b;
    y_exp[GATE_XNOR] = ~(a ^ b);
    y_exp[GATE_INV]  = ~a;
  end
endmodule

// File: rtl/gate_vector_sequencer.sv
// Sweeps a/b through 00,10,01,11, holding each HOLD_CYCLES cycles, and scores the gate outputs.
// Sweep takes 4*HOLD_CYCLES cycles after start; start is ignored while busy, no backpressure.
module gate_vector_sequencer
  import boolean_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int NUM_GATES   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] gate_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [NUM_GATES-1:0] err_mask
);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 a_q, a_d, b_q, b_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;
  logic [NUM_GATES-1:0] err_mask_q, err_mask_d;
  logic [6:0]           y_exp;
  logic [NUM_GATES-1:0] mismatch;

  // a_q/b_q always equal the vector at idx_q while applying, so they feed the reference.
  gate_expected u_exp (
    .a     (a_q),
    .b     (b_q),
    .y_exp (y_exp)
  );

  assign mismatch = gate_y ^ y_exp;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_APPLY;
          idx_d       = 2'd0;
          cnt_d       = 8'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          err_mask_d  = '0;
        end
      end
      ST_APPLY: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d       = 8'd0;
          err_mask_d  = err_mask_q | mismatch;
          err_count_d = err_count_q + popcount7(mismatch);
          if (idx_q == 2'(NUM_VECTORS - 1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            idx_d = idx_q + 2'd1;
            a_d   = idx_d[0];
            b_d   = idx_d[1];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_mask  = err_mask_q;
endmodule
